// File: rtl/hms_controller_pkg.sv
// Shared mode/position encodings for the clock controller and the counter-bank mux.
package hms_controller_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SETUP     = 2'd1,
    MODE_ALARM     = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int unsigned NUM_BTN = 4;

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

  // Position cycles through three fields only; encoding 3 never appears.
  function automatic pos_e next_pos(input pos_e p);
    return (p == POS_HOUR) ? POS_SEC : pos_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low push-button debouncer: synchroniser, stability counter, one pulse per press.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q;

  // Count samples that disagree with the accepted level; any agreeing sample restarts.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], i_btn_n};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= stable_q & ~stable_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/hms_controller.sv
// Button handling, mode/position FSM and count-pulse generation for the h/m/s counter bank.
module hms_controller
  import hms_controller_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  input  logic       i_tick_1hz,
  input  logic       i_tick_100hz,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  input  logic       i_sw_hit_ssec,
  input  logic       i_sw_hit_sec,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_clk,
  output logic       o_min_clk,
  output logic       o_hour_clk,
  output logic       o_alarm_sec_clk,
  output logic       o_alarm_min_clk,
  output logic       o_alarm_hour_clk,
  output logic       o_sw_ssec_clk,
  output logic       o_sw_sec_clk,
  output logic       o_sw_min_clk,
  output logic       o_alarm_en,
  output logic       o_stopwatch_en
);

  logic [NUM_BTN-1:0] btn_n, press;
  assign btn_n = {i_sw3, i_sw2, i_sw1, i_sw0};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn_n(btn_n[g]),
      .o_press(press[g])
    );
  end

  mode_e      mode_q, mode_d;
  pos_e       pos_q, pos_d;
  logic       alarm_en_q, alarm_en_d;
  logic       sw_en_q, sw_en_d;
  logic [3:0] hit_q, hit, rise;
  logic [8:0] pulse_q, pulse_d;
  logic       set_sec, set_min, set_hour, in_alarm;

  assign hit  = {i_sw_hit_sec, i_sw_hit_ssec, i_max_hit_min, i_max_hit_sec};
  assign rise = hit & ~hit_q;

  always_comb begin
    mode_d     = mode_q;
    pos_d      = pos_q;
    alarm_en_d = alarm_en_q;
    sw_en_d    = sw_en_q;
    pulse_d    = '0;

    if (press[0]) begin
      mode_d = next_mode(mode_q);
      pos_d  = POS_SEC;
    end else if (press[1] && (mode_q == MODE_SETUP || mode_q == MODE_ALARM)) begin
      pos_d = next_pos(pos_q);
    end

    if (press[3]) begin
      if (mode_q == MODE_ALARM)     alarm_en_d = ~alarm_en_q;
      if (mode_q == MODE_STOPWATCH) sw_en_d    = ~sw_en_q;
    end

    // The field being set takes the sw2 press; its normal source (tick or carry) is dropped.
    set_sec  = (mode_q == MODE_SETUP) && (pos_q == POS_SEC);
    set_min  = (mode_q == MODE_SETUP) && (pos_q == POS_MIN);
    set_hour = (mode_q == MODE_SETUP) && (pos_q == POS_HOUR);
    in_alarm = (mode_q == MODE_ALARM);

    pulse_d[0] = set_sec  ? press[2] : i_tick_1hz;
    pulse_d[1] = set_min  ? press[2] : rise[0];
    pulse_d[2] = set_hour ? press[2] : rise[1];
    pulse_d[3] = in_alarm && (pos_q == POS_SEC)  && press[2];
    pulse_d[4] = in_alarm && (pos_q == POS_MIN)  && press[2];
    pulse_d[5] = in_alarm && (pos_q == POS_HOUR) && press[2];
    pulse_d[6] = i_tick_100hz & ~sw_en_q;
    pulse_d[7] = rise[2] & ~sw_en_q;
    pulse_d[8] = rise[3] & ~sw_en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_CLOCK;
      pos_q      <= POS_SEC;
      alarm_en_q <= 1'b0;
      sw_en_q    <= 1'b1;
      hit_q      <= '0;
      pulse_q    <= '0;
    end else begin
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      alarm_en_q <= alarm_en_d;
      sw_en_q    <= sw_en_d;
      hit_q      <= hit;
      pulse_q    <= pulse_d;
    end
  end

  assign o_mode           = mode_q;
  assign o_position       = pos_q;
  assign o_alarm_en       = alarm_en_q;
  assign o_stopwatch_en   = sw_en_q;
  assign o_sec_clk        = pulse_q[0];
  assign o_min_clk        = pulse_q[1];
  assign o_hour_clk       = pulse_q[2];
  assign o_alarm_sec_clk  = pulse_q[3];
  assign o_alarm_min_clk  = pulse_q[4];
  assign o_alarm_hour_clk = pulse_q[5];
  assign o_sw_ssec_clk    = pulse_q[6];
  assign o_sw_sec_clk     = pulse_q[7];
  assign o_sw_min_clk     = pulse_q[8];

endmodule
